if_id_queue: RTL

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a circular buffer that absorbs fetch groups
// and presents the oldest ISSUE_WIDTH instructions to decode.

`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif

package if_id_queue_pkg;

    localparam int ISSUE_WIDTH = `ISSUE_WIDTH;

    typedef struct packed {
        logic [ISSUE_WIDTH-1:0]       valid;
        logic [ISSUE_WIDTH-1:0][31:0] inst;
        logic [ISSUE_WIDTH-1:0][31:0] PC;
    } IF_ID_PACKET;

endpackage

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [ISSUE_WIDTH-1:0]        fetch_valid,
    input  logic [ISSUE_WIDTH-1:0][31:0]  fetch_inst,
    input  logic [ISSUE_WIDTH-1:0][31:0]  fetch_pc,
    output logic                          fetch_ready,
    input  logic [ISSUE_WIDTH-1:0]        stall,
    output IF_ID_PACKET                   if_id_q,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]       inst_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic [PTR_W-1:0]  rd_idx   [ISSUE_WIDTH];
    logic [PTR_W-1:0]  wr_idx   [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] slot_valid;

    logic [CNT_W-1:0]  free_slots;
    logic [CNT_W-1:0]  enq_cnt;
    logic [CNT_W-1:0]  deq_cnt;
    logic              enq_run;
    logic              deq_blocked;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    genvar g;
    for (g = 0; g < ISSUE_WIDTH; g++) begin : g_slot_idx
        assign rd_idx[g]     = head + PTR_W'(g);
        assign wr_idx[g]     = tail + PTR_W'(g);
        assign slot_valid[g] = (CNT_W'(g) < count);
    end

    always_comb begin
        if_id_q = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if_id_q.valid[i] = slot_valid[i];
            if_id_q.inst[i]  = inst_mem[rd_idx[i]];
            if_id_q.PC[i]    = pc_mem[rd_idx[i]];
        end
    end

    // Readiness looks only at registered occupancy, never at this cycle's dequeue.
    assign free_slots  = CNT_W'(DEPTH) - count;
    assign fetch_ready = (free_slots >= CNT_W'(ISSUE_WIDTH));

    always_comb begin
        enq_cnt = '0;
        enq_run = 1'b1;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (enq_run && fetch_valid[i]) begin
                enq_cnt = enq_cnt + CNT_W'(1);
            end else begin
                enq_run = 1'b0;
            end
        end
        if (!fetch_ready || flush) begin
            enq_cnt = '0;
        end
    end

    // The first stalled valid slot holds itself and everything younger.
    always_comb begin
        deq_cnt     = '0;
        deq_blocked = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (!deq_blocked && slot_valid[i]) begin
                if (stall[i]) begin
                    deq_blocked = 1'b1;
                end else begin
                    deq_cnt = deq_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            if (CNT_W'(j) < enq_cnt) begin
                inst_mem[wr_idx[j]] <= fetch_inst[j];
                pc_mem[wr_idx[j]]   <= fetch_pc[j];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_cnt);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + enq_cnt - deq_cnt;
        end
    end

endmodule
